// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage, the IF/ID register and the decoder.
package if_fetch_unit_pkg;

  localparam int          PC_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef logic [31:0] inst_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bundle between the fetch unit and instruction memory.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
);

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  inst_t               imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO with flush; the head word is always visible, and push-when-full or pop-when-empty is ignored.
module if_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] incr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count_q < CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= incr(wr_ptr);
      if (do_pop)  rd_ptr <= incr(rd_ptr);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited memory requests and buffers returned words for IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  MAX_OUTST  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  if_fetch_unit_if.master     imem,
  output logic                if_valid,
  output logic [PC_WIDTH-1:0] if_pc,
  output inst_t               if_inst
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [OCW-1:0]         outst_cnt;
  logic [OCW-1:0]         discard_cnt;
  logic [OCW-1:0]         outst_next;
  logic [FCW-1:0]         inst_cnt;
  logic [OCW-1:0]         tag_cnt;
  logic [PC_WIDTH-1:0]    tag_head;
  logic [PC_WIDTH+31:0]   inst_head;
  logic                   granted;
  logic                   rsp_ok;
  logic                   push_inst;
  logic                   pop_inst;

  // Credit check uses registered counts only, so req never depends on this cycle's gnt/rvalid.
  assign imem.imem_req  = !rst && !redirect_valid
                       && (int'(inst_cnt) + int'(outst_cnt) < FIFO_DEPTH)
                       && (int'(outst_cnt) < MAX_OUTST);
  assign imem.imem_addr = fetch_pc;

  assign granted    = imem.imem_req && imem.imem_gnt;
  assign rsp_ok     = imem.imem_rvalid && (outst_cnt != '0);
  assign push_inst  = rsp_ok && (discard_cnt == '0) && !redirect_valid;
  assign pop_inst   = if_valid && !stall && !redirect_valid;
  assign outst_next = outst_cnt + OCW'(granted) - OCW'(rsp_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outst_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      outst_cnt <= outst_next;
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc & ~PC_WIDTH'(3);
        discard_cnt <= outst_next;
      end else begin
        if (granted) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (rsp_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
      end
    end
  end

  // Tag FIFO pairs each returned word with its granted address; a redirect drops every live tag.
  if_fifo #(.WIDTH(PC_WIDTH), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (granted),
    .pop   (push_inst),
    .flush (redirect_valid),
    .din   (fetch_pc),
    .head  (tag_head),
    .count (tag_cnt)
  );

  if_fifo #(.WIDTH(PC_WIDTH + 32), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_inst),
    .pop   (pop_inst),
    .flush (redirect_valid),
    .din   ({tag_head, imem.imem_rdata}),
    .head  (inst_head),
    .count (inst_cnt)
  );

  assign if_valid = (inst_cnt != '0);
  assign if_pc    = if_valid ? inst_head[PC_WIDTH+31:32] : '0;
  assign if_inst  = if_valid ? inst_head[31:0] : NOP_INST;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem.imem_rvalid && (outst_cnt == '0)));

  a_tag_accounting: assert property (@(posedge clk) disable iff (rst)
    int'(tag_cnt) + int'(discard_cnt) == int'(outst_cnt));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised and directed bench for if_fetch_unit against an in-order instruction-stream reference model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch_unit_if #(.PC_WIDTH(32)) imem ();

  if_fetch_unit #(
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4),
    .MAX_OUTST  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } rsp_t;

  rsp_t        rq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_pct = 100;
  bit          force_gnt = 1'b0;
  int          last_ready = 0;
  int          pops = 0;
  logic [31:0] exp_pc;
  logic        seen_req;
  logic [31:0] seen_addr;
  logic        seen_valid;
  logic [31:0] seen_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // One clock cycle: memory model responds, reference model tracks the consumed instruction stream.
  task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc);
    bit g;
    int rdy;
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    if (rq.size() > 0 && rq[0].ready <= cyc) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = mem_word(rq[0].addr);
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = $urandom;
    end
    #1;
    seen_req   = imem.imem_req;
    seen_addr  = imem.imem_addr;
    seen_valid = if_valid;
    seen_pc    = if_pc;
    g = force_gnt || ($urandom_range(99) < gnt_pct);
    imem.imem_gnt = g;
    if (!if_valid) begin
      checkOutput("idle_pc", if_pc, 32'h0);
      checkOutput("idle_inst", if_inst, NOP_INST);
    end
    if (r) begin
      exp_pc = rpc & ~32'h3;
    end else if (if_valid && !s) begin
      checkOutput("pop_pc", if_pc, exp_pc);
      checkOutput("pop_inst", if_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (seen_req && g) begin
      rdy = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
      rq.push_back('{addr: seen_addr, ready: rdy});
      last_ready = rdy;
    end
    if (imem.imem_rvalid) void'(rq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitFirstValid(input string tag, input logic [31:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (seen_valid) begin
        found = 1'b1;
        checkOutput(tag, seen_pc, want);
      end
    end
    if (!found) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    bit found;
    int pops_before;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'h0;
    exp_pc = 32'h0;
    #2;
    checkOutput("rst_req", imem.imem_req, 1'b0);
    checkOutput("rst_valid", if_valid, 1'b0);
    checkOutput("rst_pc", if_pc, 32'h0);
    checkOutput("rst_inst", if_inst, NOP_INST);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset release with zero-wait memory: addresses 0,4,8 and valid two cycles after the first request.
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c0_addr", {seen_req, seen_addr}, {1'b1, 32'h0});
    checkOutput("c0_valid", seen_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c1_addr", {seen_req, seen_addr}, {1'b1, 32'h4});
    checkOutput("c1_valid", seen_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c2_addr", {seen_req, seen_addr}, {1'b1, 32'h8});
    checkOutput("c2_valid", {seen_valid, seen_pc}, {1'b1, 32'h0});
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Stall for 6 cycles fills the buffer and stops requests; release drains 4 back-to-back.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stall_full_req", seen_req, 1'b0);
    checkOutput("stall_full_valid", seen_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("drain_valid", seen_valid, 1'b1);
    end

    // Slow memory with two requests in flight, then redirect to 0x100.
    lat = 3;
    applyStimulus(1'b0, 1'b1, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rq.size() == 2) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("two_outstanding", found, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("redir_req_low", seen_req, 1'b0);
    waitFirstValid("redir100_pc", 32'h100);

    // Redirect to an unaligned target in the same cycle as rvalid and gnt.
    lat = 2;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rq.size() > 0 && rq[0].ready <= cyc) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("rvalid_pending", found, 1'b1);
    force_gnt = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h203);
    force_gnt = 1'b0;
    checkOutput("redir203_req_low", seen_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir203_addr", {seen_req, seen_addr}, {1'b1, 32'h200});
    waitFirstValid("redir203_pc", 32'h200);

    // Asynchronous reset mid-cycle with requests outstanding; a late rvalid lands while reset is held.
    lat = 3;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    #1;
    checkOutput("async_req", imem.imem_req, 1'b0);
    checkOutput("async_valid", if_valid, 1'b0);
    checkOutput("async_pc", if_pc, 32'h0);
    checkOutput("async_inst", if_inst, NOP_INST);
    rq.delete();
    last_ready = 0;
    @(posedge clk);
    #1;
    cyc++;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    #2;
    checkOutput("late_rvalid_valid", if_valid, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    imem.imem_rvalid = 1'b0;
    rst = 1'b0;
    exp_pc = 32'h0;
    last_ready = cyc;
    lat = 1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("restart_addr", {seen_req, seen_addr}, {1'b1, 32'h0});
    waitFirstValid("restart_pc", 32'h0);

    // PC wraps from the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr0", {seen_req, seen_addr}, {1'b1, 32'hFFFF_FFFC});
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr1", {seen_req, seen_addr}, {1'b1, 32'h0000_0000});
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Random stall, redirect, grant and latency mix.
    gnt_pct = 70;
    pops_before = pops;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(3, 1);
      applyStimulus($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom);
    end
    checkOutput("random_progress", (pops - pops_before) > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
